// File: rtl/swo_uart_rx_pkg.sv
// Shared state encodings, framing limits and clamp helpers for the SWO UART receiver.
package swo_uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd8;
  localparam logic [1:0] STOP_BITS_MIN = 2'd1;
  localparam logic [1:0] STOP_BITS_MAX = 2'd2;
  localparam int unsigned DEFAULT_DIV  = 7;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
    if (bits < DATA_BITS_MIN) return DATA_BITS_MIN;
    if (bits > DATA_BITS_MAX) return DATA_BITS_MAX;
    return bits;
  endfunction

  function automatic logic [1:0] clamp_stop_bits(input logic [1:0] bits);
    if (bits < STOP_BITS_MIN) return STOP_BITS_MIN;
    if (bits > STOP_BITS_MAX) return STOP_BITS_MAX;
    return bits;
  endfunction

endpackage

// File: rtl/swo_uart_rx_if.sv
// Received-character bus from the SWO UART receiver to the trace framing logic.
interface swo_uart_rx_if;
  logic [7:0] O_swo_data;
  logic       O_swo_data_valid;
  logic       O_framing_error;
  logic       O_busy;

  modport master (
    output O_swo_data,
    output O_swo_data_valid,
    output O_framing_error,
    output O_busy
  );

  modport slave (
    input O_swo_data,
    input O_swo_data_valid,
    input O_framing_error,
    input O_busy
  );
endinterface

// File: rtl/swo_uart_rx_bit_timer.sv
// Bit-period down-counter: ticks when it reaches zero, then reloads so the period is reload+1 cycles.
module swo_bit_timer #(
  parameter int pDIV_WIDTH = 8
) (
  input  logic                  uart_clk,
  input  logic                  reset_i,
  input  logic                  i_load,
  input  logic [pDIV_WIDTH-1:0] i_load_val,
  input  logic [pDIV_WIDTH-1:0] i_reload_val,
  output logic                  o_tick
);

  logic [pDIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge uart_clk) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt == '0) begin
      r_cnt <= i_reload_val;
    end else begin
      r_cnt <= r_cnt - {{(pDIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/swo_uart_rx.sv
// SWO UART (NRZ) receiver: synchronises the pin, samples mid-bit and emits one strobe per frame.
module swo_uart_rx
  import swo_uart_rx_pkg::*;
#(
  parameter int pSYNC_STAGES = 2,
  parameter int pDIV_WIDTH   = 8
) (
  input  logic                  uart_clk,
  input  logic                  reset_i,
  input  logic                  I_swo,
  input  logic                  I_swo_enable,
  input  logic [pDIV_WIDTH-1:0] I_swo_bitrate_div,
  input  logic [1:0]            I_uart_stop_bits,
  input  logic [3:0]            I_uart_data_bits,
  swo_uart_rx_if.master         o_rx
);

  logic [pSYNC_STAGES-1:0] r_swo_sync;
  logic                    w_swo_s;

  // Preset high so reset does not look like a start bit.
  always_ff @(posedge uart_clk) begin
    if (reset_i) begin
      r_swo_sync <= '1;
    end else begin
      r_swo_sync <= {r_swo_sync[pSYNC_STAGES-2:0], I_swo};
    end
  end

  assign w_swo_s = r_swo_sync[pSYNC_STAGES-1];

  state_t                r_state;
  logic [pDIV_WIDTH-1:0] r_div;
  logic [3:0]            r_data_bits;
  logic [1:0]            r_stop_bits;
  logic [2:0]            r_bit_idx;
  logic [1:0]            r_stop_idx;
  logic [7:0]            r_shift;
  logic [7:0]            r_data;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_busy;

  logic                  w_load;
  logic                  w_tick;
  logic [pDIV_WIDTH-1:0] w_half_div;

  assign w_load     = (r_state == ST_IDLE) && I_swo_enable && !w_swo_s;
  assign w_half_div = I_swo_bitrate_div >> 1;

  swo_bit_timer #(
    .pDIV_WIDTH (pDIV_WIDTH)
  ) u_bit_timer (
    .uart_clk     (uart_clk),
    .reset_i      (reset_i),
    .i_load       (w_load),
    .i_load_val   (w_half_div),
    .i_reload_val (r_div),
    .o_tick       (w_tick)
  );

  always_ff @(posedge uart_clk) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_data_bits <= DATA_BITS_MAX;
      r_stop_bits <= STOP_BITS_MIN;
      r_bit_idx   <= '0;
      r_stop_idx  <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (!I_swo_enable) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Settings are frozen per frame so live register writes cannot corrupt it.
            if (!w_swo_s) begin
              r_div       <= I_swo_bitrate_div;
              r_data_bits <= clamp_data_bits(I_uart_data_bits);
              r_stop_bits <= clamp_stop_bits(I_uart_stop_bits);
              r_shift     <= '0;
              r_bit_idx   <= '0;
              r_stop_idx  <= '0;
              r_state     <= ST_START;
              r_busy      <= 1'b1;
            end
          end
          ST_START: begin
            if (w_tick) begin
              if (w_swo_s) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (w_tick) begin
              r_shift[r_bit_idx] <= w_swo_s;
              if ({1'b0, r_bit_idx} == r_data_bits - 4'd1) begin
                r_state <= ST_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end
          end
          ST_STOP: begin
            if (w_tick) begin
              if (!w_swo_s) begin
                r_ferr  <= 1'b1;
                r_state <= ST_WAIT_IDLE;
              end else if (r_stop_idx == r_stop_bits - 2'd1) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_stop_idx <= r_stop_idx + 2'd1;
              end
            end
          end
          ST_WAIT_IDLE: begin
            // A line stuck low must not be re-read as a stream of frames.
            if (w_swo_s) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rx.O_swo_data       = r_data;
  assign o_rx.O_swo_data_valid = r_valid;
  assign o_rx.O_framing_error  = r_ferr;
  assign o_rx.O_busy           = r_busy;

endmodule

// File: tb/tb_swo_uart_rx.sv
// Scoreboard bench for swo_uart_rx: stimulus pushes expected strobes, a monitor pops and compares.
module tb_swo_uart_rx;
  import swo_uart_rx_pkg::*;

  logic       uart_clk = 1'b0;
  logic       reset_i  = 1'b1;
  logic       I_swo    = 1'b1;
  logic       I_swo_enable = 1'b0;
  logic [7:0] I_swo_bitrate_div = 8'(DEFAULT_DIV);
  logic [1:0] I_uart_stop_bits  = 2'd1;
  logic [3:0] I_uart_data_bits  = 4'd8;

  swo_uart_rx_if rx_if();

  swo_uart_rx #(
    .pSYNC_STAGES (2),
    .pDIV_WIDTH   (8)
  ) dut (
    .uart_clk          (uart_clk),
    .reset_i           (reset_i),
    .I_swo             (I_swo),
    .I_swo_enable      (I_swo_enable),
    .I_swo_bitrate_div (I_swo_bitrate_div),
    .I_uart_stop_bits  (I_uart_stop_bits),
    .I_uart_data_bits  (I_uart_data_bits),
    .o_rx              (rx_if)
  );

  always #5 uart_clk = ~uart_clk;

  int cyc = 0;
  always @(posedge uart_clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;     // 1 = valid strobe, 2 = framing error
    logic [7:0] data;
    int         cyc_at;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge uart_clk) begin
    if (!reset_i && (rx_if.O_swo_data_valid || rx_if.O_framing_error)) begin
      if (rx_if.O_swo_data_valid && rx_if.O_framing_error) chk("strobe_exclusive", 1, 0);
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", rx_if.O_swo_data_valid ? 1 : 2, 0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("strobe kind=%0d data=0x%02h cycle=%0d (want kind=%0d data=0x%02h cycle=%0d)",
                 rx_if.O_swo_data_valid ? 1 : 2, rx_if.O_swo_data, cyc,
                 mon_e.kind, mon_e.data, mon_e.cyc_at);
        chk("strobe_kind", rx_if.O_swo_data_valid ? 1 : 2, mon_e.kind);
        chk("strobe_data", int'(rx_if.O_swo_data), int'(mon_e.data));
        chk("strobe_cycle", cyc, mon_e.cyc_at);
      end
    end
  end

  // Every drive happens 1 time unit after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge uart_clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int bc);
    I_swo = v;
    wait_cyc(bc);
  endtask

  // Start strobe lands 3 cycles after the pin falls (2 sync stages + IDLE decision).
  task automatic send_frame(input logic [7:0] d, input int nd, input int ns, input logic stop_v,
                            input int bc, input int div, input int kind, input logic [7:0] exp_d);
    exp_t e;
    if (kind != 0) begin
      e.kind   = kind;
      e.data   = exp_d;
      e.cyc_at = cyc + 3 + (div >> 1) + (div + 1) * (nd + ns) + 1;
      sb_q.push_back(e);
    end
    drive(1'b0, bc);
    for (int i = 0; i < nd; i++) drive(d[i], bc);
    for (int i = 0; i < ns; i++) drive(stop_v, bc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    errors++;
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int c;
    wait_cyc(5);
    chk("reset_data",  int'(rx_if.O_swo_data), 0);
    chk("reset_valid", int'(rx_if.O_swo_data_valid), 0);
    chk("reset_ferr",  int'(rx_if.O_framing_error), 0);
    chk("reset_busy",  int'(rx_if.O_busy), 0);
    reset_i = 1'b0;
    I_swo_enable = 1'b1;
    wait_cyc(10);

    // 1: 8N1 0xA5, latency and busy window.
    c = cyc;
    fork
      send_frame(8'hA5, 8, 1, 1'b1, 8, 7, 1, 8'hA5);
      begin
        wait_cyc(2);
        chk("t1_busy_pre", int'(rx_if.O_busy), 0);
        wait_cyc(1);
        chk("t1_busy_detect", int'(rx_if.O_busy), 1);
        wait_cyc(75);
        chk("t1_busy_last", int'(rx_if.O_busy), 1);
        wait_cyc(1);
        chk("t1_busy_done", int'(rx_if.O_busy), 0);
      end
    join
    $display("t1 started at cycle %0d", c);
    wait_cyc(10);

    // 2: 5 data bits, 2 stop bits, back-to-back frames.
    I_uart_data_bits = 4'd5;
    I_uart_stop_bits = 2'd2;
    send_frame(8'h1F, 5, 2, 1'b1, 8, 7, 1, 8'h1F);
    send_frame(8'h0A, 5, 2, 1'b1, 8, 7, 1, 8'h0A);
    wait_cyc(10);

    // 3: framing error, stuck-low line, then recovery.
    I_uart_data_bits = 4'd8;
    I_uart_stop_bits = 2'd1;
    send_frame(8'hC3, 8, 1, 1'b0, 8, 7, 2, 8'h0A);
    drive(1'b0, 100);
    drive(1'b1, 20);
    send_frame(8'h3C, 8, 1, 1'b1, 8, 7, 1, 8'h3C);
    wait_cyc(10);

    // 4: 2-cycle glitch is a false start.
    c = cyc;
    drive(1'b0, 2);
    drive(1'b1, 1);
    chk("t4_busy_false_start", int'(rx_if.O_busy), 1);
    wait_cyc(4);
    chk("t4_busy_back_idle", int'(rx_if.O_busy), 0);
    wait_cyc(20);

    // 5: enable dropped mid-DATA, then a clean frame.
    fork
      send_frame(8'h55, 8, 1, 1'b1, 8, 7, 0, 8'h00);
      begin
        wait_cyc(40);
        chk("t5_busy_before_drop", int'(rx_if.O_busy), 1);
        I_swo_enable = 1'b0;
        wait_cyc(1);
        chk("t5_busy_after_drop", int'(rx_if.O_busy), 0);
      end
    join
    wait_cyc(10);
    I_swo_enable = 1'b1;
    wait_cyc(5);
    send_frame(8'h55, 8, 1, 1'b1, 8, 7, 1, 8'h55);
    wait_cyc(10);

    // 6: divider changed mid-frame applies only to the next frame.
    fork
      send_frame(8'h96, 8, 1, 1'b1, 8, 7, 1, 8'h96);
      begin
        wait_cyc(30);
        I_swo_bitrate_div = 8'd15;
      end
    join
    drive(1'b1, 40);
    send_frame(8'h69, 8, 1, 1'b1, 16, 15, 1, 8'h69);
    wait_cyc(30);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
